// File: rtl/io_pkg.sv
// ============================================================================
//  Module  : io_pkg
//  Brief   : Shared defaults and counter-width helper for the button IO block.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package io_pkg;

    localparam int IO_NUM_CH_DEFAULT   = 4;
    localparam int IO_DEBOUNCE_DEFAULT = 16;

    // Width of a counter that must reach cycles-1; never narrower than one bit.
    function automatic int cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage : io_pkg

`default_nettype wire

// File: rtl/io_debounce_ch.sv
// ============================================================================
//  Module  : io_debounce_ch
//  Brief   : One button channel: polarity fix, 2-flop sync, debounce, rise pulse.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module io_debounce_ch
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
    parameter bit ACTIVE_HI       = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int              CNT_W      = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic             w_pin;
    logic             w_done;
    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    assign w_pin  = btn ^ ~ACTIVE_HI;
    assign w_done = (r_s2 != r_level) && (r_cnt == c_cnt_last);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= w_pin;
            r_s2 <= r_s1;
            // Any return to the current level restarts qualification from zero.
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign level = r_level;
    assign rise  = w_done & r_s2;

endmodule : io_debounce_ch

`default_nettype wire

// File: rtl/io_button_ctrl.sv
// ============================================================================
//  Module  : io_button_ctrl
//  Brief   : NUM_CH debounced buttons with sticky press events, overflow flags
//            and a masked clear from the processor.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module io_button_ctrl
    import io_pkg::*;
#(
    parameter int                NUM_CH          = IO_NUM_CH_DEFAULT,
    parameter int                DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
    parameter logic [NUM_CH-1:0] BTN_ACTIVE_HI   = {NUM_CH{1'b1}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] btn_in,
    input  logic              clr_valid,
    input  logic [NUM_CH-1:0] clr_mask,
    output logic [NUM_CH-1:0] io_level,
    output logic [NUM_CH-1:0] io_event,
    output logic              io_event_any,
    output logic [NUM_CH-1:0] io_overflow
);

    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] r_event;
    logic [NUM_CH-1:0] r_overflow;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        io_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_HI       (BTN_ACTIVE_HI[i])
        ) u_deb (
            .clock (clock),
            .reset (reset),
            .btn   (btn_in[i]),
            .level (io_level[i]),
            .rise  (w_rise[i])
        );
    end

    assign w_clr = {NUM_CH{clr_valid}} & clr_mask;

    // A press landing on a clear keeps the new event but drops the stale overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_event    <= '0;
            r_overflow <= '0;
        end else begin
            r_event    <= (r_event & ~w_clr) | w_rise;
            r_overflow <= (r_overflow | (w_rise & r_event)) & ~w_clr;
        end
    end

    assign io_event     = r_event;
    assign io_event_any = |r_event;
    assign io_overflow  = r_overflow;

endmodule : io_button_ctrl

`default_nettype wire

// File: tb/tb_io_button_ctrl.sv
// Bench for io_button_ctrl: two instances (all active-high, ch0 active-low)
// compared every cycle against a run-length reference model, plus directed checks.
`default_nettype none

module tb_io_button_ctrl;

    localparam int         NCH  = 4;
    localparam int         DB   = 4;
    localparam logic [3:0] HI_A = 4'hF;
    localparam logic [3:0] HI_B = 4'hE;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic [3:0] btn_in    = '0;
    logic       clr_valid = 1'b0;
    logic [3:0] clr_mask  = '0;

    logic [3:0] lvl_a, ev_a, ov_a, lvl_b, ev_b, ov_b;
    logic       any_a, any_b;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    // Reference model state, index 0 = instance A, 1 = instance B.
    logic [3:0] m_s1 [2];
    logic [3:0] m_s2 [2];
    logic [3:0] m_lvl[2];
    logic [3:0] m_ev [2];
    logic [3:0] m_ov [2];
    int         m_run[2][4];

    always #5 clock = ~clock;

    io_button_ctrl #(.NUM_CH(NCH), .DEBOUNCE_CYCLES(DB), .BTN_ACTIVE_HI(HI_A)) u_dut_a (
        .clock(clock), .reset(reset), .btn_in(btn_in), .clr_valid(clr_valid),
        .clr_mask(clr_mask), .io_level(lvl_a), .io_event(ev_a),
        .io_event_any(any_a), .io_overflow(ov_a));

    io_button_ctrl #(.NUM_CH(NCH), .DEBOUNCE_CYCLES(DB), .BTN_ACTIVE_HI(HI_B)) u_dut_b (
        .clock(clock), .reset(reset), .btn_in(btn_in), .clr_valid(clr_valid),
        .clr_mask(clr_mask), .io_level(lvl_b), .io_event(ev_b),
        .io_event_any(any_b), .io_overflow(ov_b));

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s1[k] = '0; m_s2[k] = '0; m_lvl[k] = '0; m_ev[k] = '0; m_ov[k] = '0;
            for (int i = 0; i < NCH; i++) m_run[k][i] = 0;
        end
    endfunction

    // A level is accepted once the synchronised pin has disagreed with it on DB consecutive edges.
    function automatic void model_edge();
        logic [3:0] hi;
        logic [3:0] rise;
        logic [3:0] clr;
        clr = clr_valid ? clr_mask : 4'h0;
        for (int k = 0; k < 2; k++) begin
            hi   = (k == 0) ? HI_A : HI_B;
            rise = '0;
            for (int i = 0; i < NCH; i++) begin
                if (m_s2[k][i] != m_lvl[k][i]) begin
                    m_run[k][i]++;
                    if (m_run[k][i] == DB) begin
                        m_lvl[k][i] = m_s2[k][i];
                        m_run[k][i] = 0;
                        rise[i]     = m_lvl[k][i];
                    end
                end else begin
                    m_run[k][i] = 0;
                end
            end
            m_ov[k] = (m_ov[k] | (rise & m_ev[k])) & ~clr;
            m_ev[k] = (m_ev[k] & ~clr) | rise;
            m_s2[k] = m_s1[k];
            m_s1[k] = btn_in ^ ~hi;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_level", {28'h0, lvl_a}, {28'h0, m_lvl[0]});
        chk("a_event", {28'h0, ev_a},  {28'h0, m_ev[0]});
        chk("a_any",   {31'h0, any_a}, {31'h0, |m_ev[0]});
        chk("a_ovf",   {28'h0, ov_a},  {28'h0, m_ov[0]});
        chk("b_level", {28'h0, lvl_b}, {28'h0, m_lvl[1]});
        chk("b_event", {28'h0, ev_b},  {28'h0, m_ev[1]});
        chk("b_any",   {31'h0, any_b}, {31'h0, |m_ev[1]});
        chk("b_ovf",   {28'h0, ov_b},  {28'h0, m_ov[1]});
    endtask

    task automatic step(input logic [3:0] b, input logic cv, input logic [3:0] cm);
        btn_in    = b;
        clr_valid = cv;
        clr_mask  = cm;
        @(posedge clock);
        if (!reset) model_reset();
        else        model_edge();
        #1;
        check_all();
    endtask

    // Edges from applying b until the chosen level bit goes high; -1 if it never does.
    task automatic measure(input int inst, input int ch, input logic [3:0] b, output int l);
        l = -1;
        for (int e = 1; e <= 20; e++) begin
            step(b, 1'b0, 4'h0);
            if ((inst == 0) ? lvl_a[ch] : lvl_b[ch]) begin
                l = e;
                break;
            end
        end
    endtask

    initial begin
        model_reset();
        #3;
        chk("rst_level", {28'h0, lvl_a}, 32'h0);
        chk("rst_event", {28'h0, ev_a},  32'h0);
        chk("rst_any",   {31'h0, any_a}, 32'h0);
        chk("rst_ovf",   {28'h0, ov_a},  32'h0);
        repeat (2) step(4'h0, 1'b0, 4'h0);
        reset = 1'b1;
        repeat (3) step(4'h0, 1'b0, 4'h0);

        // Clean press on ch0
        measure(0, 0, 4'b0001, lat);
        chk("t1_latency", lat, 1 + 1 + DB);
        chk("t1_event", {28'h0, ev_a}, 32'h1);
        chk("t1_any", {31'h0, any_a}, 32'h1);
        repeat (8) step(4'h0, 1'b0, 4'h0);

        // Bouncing ch1
        step(4'b0010, 1'b0, 4'h0);
        step(4'b0000, 1'b0, 4'h0);
        step(4'b0010, 1'b0, 4'h0);
        step(4'b0000, 1'b0, 4'h0);
        measure(0, 1, 4'b0010, lat);
        chk("t2_latency", lat, 1 + 1 + DB);
        chk("t2_event", {31'h0, ev_a[1]}, 32'h1);
        chk("t2_single", {31'h0, ov_a[1]}, 32'h0);
        repeat (8) step(4'b0010, 1'b0, 4'h0);
        repeat (8) step(4'h0, 1'b0, 4'h0);

        // Overflow then masked clear on ch2
        repeat (8) step(4'b0100, 1'b0, 4'h0);
        repeat (8) step(4'b0000, 1'b0, 4'h0);
        repeat (8) step(4'b0100, 1'b0, 4'h0);
        chk("t3_ovf", {28'h0, ov_a}, 32'h4);
        step(4'b0100, 1'b1, 4'b0100);
        chk("t3_clr_ev", {31'h0, ev_a[2]}, 32'h0);
        chk("t3_clr_ov", {31'h0, ov_a[2]}, 32'h0);
        chk("t3_keep_ev0", {31'h0, ev_a[0]}, 32'h1);
        step(4'b0100, 1'b1, 4'b0000);
        step(4'b0100, 1'b0, 4'b1111);
        chk("t3_noclr", {28'h0, ev_a}, 32'h3);
        repeat (8) step(4'h0, 1'b0, 4'h0);

        // Clear colliding with accept-rise on ch3 while an old event is pending
        repeat (8) step(4'b1000, 1'b0, 4'h0);
        repeat (8) step(4'b0000, 1'b0, 4'h0);
        repeat (5) step(4'b1000, 1'b0, 4'h0);
        chk("t4_pre_level", {31'h0, lvl_a[3]}, 32'h0);
        step(4'b1000, 1'b1, 4'b1000);
        chk("t4_level", {31'h0, lvl_a[3]}, 32'h1);
        chk("t4_event", {31'h0, ev_a[3]}, 32'h1);
        chk("t4_ovf", {31'h0, ov_a[3]}, 32'h0);
        repeat (8) step(4'h0, 1'b0, 4'h0);

        // Asynchronous reset mid-debounce on ch0
        repeat (4) step(4'b0001, 1'b0, 4'h0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("t5_level", {28'h0, lvl_a}, 32'h0);
        chk("t5_event", {28'h0, ev_a}, 32'h0);
        chk("t5_any", {31'h0, any_a}, 32'h0);
        chk("t5_ovf", {28'h0, ov_a}, 32'h0);
        chk("t5_b_event", {28'h0, ev_b}, 32'h0);
        repeat (2) step(4'b0001, 1'b0, 4'h0);
        reset = 1'b1;
        measure(0, 0, 4'b0001, lat);
        chk("t5_latency", lat, 1 + 1 + DB);

        // Active-low ch0 on instance B
        chk("t6_hold", {31'h0, ev_b[0]}, 32'h0);
        measure(1, 0, 4'b0000, lat);
        chk("t6_latency", lat, 1 + 1 + DB);
        chk("t6_event", {31'h0, ev_b[0]}, 32'h1);

        // Random buttons and clears
        begin
            logic [3:0] b;
            b = '0;
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(0, 3) == 0) b[$urandom_range(0, 3)] = ~b[$urandom_range(0, 3) & 0 | 0] ^ 1'b0 ? b[0] : b[0];
                if ($urandom_range(0, 4) == 0) b = b ^ (4'h1 << $urandom_range(0, 3));
                step(b, ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_io_button_ctrl

`default_nettype wire
